// File: rtl/alu_issue.sv
// ID/EX issue stage: decodes an RV32I word plus its register read data into ALU
// controls, operands and qualifiers, held in one valid/ready pipeline register.
module alu_issue #(
   parameter int ALU_BITS      = 32,
   parameter int ALU_CTRL_BITS = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_inst,
   input  logic [ALU_BITS-1:0]      in_rdata1,
   input  logic [ALU_BITS-1:0]      in_rdata2,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ALU_CTRL_BITS-1:0] out_alu_ctrl,
   output logic                     out_alu_src,
   output logic [ALU_BITS-1:0]      out_imm,
   output logic [ALU_BITS-1:0]      out_rdata1,
   output logic [ALU_BITS-1:0]      out_rdata2,
   output logic [4:0]               out_rd,
   output logic                     out_reg_write,
   output logic                     out_mem_read,
   output logic                     out_mem_write,
   output logic                     out_branch,
   output logic                     out_br_invert,
   output logic                     out_illegal
);

   localparam logic [ALU_CTRL_BITS-1:0] C_ADD  = ALU_CTRL_BITS'(0);
   localparam logic [ALU_CTRL_BITS-1:0] C_SUB  = ALU_CTRL_BITS'(1);
   localparam logic [ALU_CTRL_BITS-1:0] C_SLL  = ALU_CTRL_BITS'(2);
   localparam logic [ALU_CTRL_BITS-1:0] C_SLT  = ALU_CTRL_BITS'(3);
   localparam logic [ALU_CTRL_BITS-1:0] C_SLTU = ALU_CTRL_BITS'(4);
   localparam logic [ALU_CTRL_BITS-1:0] C_XOR  = ALU_CTRL_BITS'(5);
   localparam logic [ALU_CTRL_BITS-1:0] C_SRL  = ALU_CTRL_BITS'(6);
   localparam logic [ALU_CTRL_BITS-1:0] C_SRA  = ALU_CTRL_BITS'(7);
   localparam logic [ALU_CTRL_BITS-1:0] C_OR   = ALU_CTRL_BITS'(8);
   localparam logic [ALU_CTRL_BITS-1:0] C_AND  = ALU_CTRL_BITS'(9);

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LOAD = 7'b0000011;
   localparam logic [6:0] OP_ST   = 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_LUI  = 7'b0110111;

   function automatic logic [ALU_CTRL_BITS-1:0] f3_ctrl(input logic [2:0] f3);
      case (f3)
         3'd0:    f3_ctrl = C_ADD;
         3'd1:    f3_ctrl = C_SLL;
         3'd2:    f3_ctrl = C_SLT;
         3'd3:    f3_ctrl = C_SLTU;
         3'd4:    f3_ctrl = C_XOR;
         3'd5:    f3_ctrl = C_SRL;
         3'd6:    f3_ctrl = C_OR;
         default: f3_ctrl = C_AND;
      endcase
   endfunction

   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u;
   logic        accept;

   logic [ALU_CTRL_BITS-1:0] d_ctrl;
   logic [31:0]              d_imm;
   logic [4:0]               d_rd;
   logic d_src, d_rw, d_mr, d_mw, d_br, d_inv, d_ill, d_zero_rs1;

   assign opcode = in_inst[6:0];
   assign funct3 = in_inst[14:12];
   assign funct7 = in_inst[31:25];
   assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
   assign imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
   assign imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
   assign imm_u  = {in_inst[31:12], 12'b0};

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      d_ctrl     = C_ADD;
      d_src      = 1'b0;
      d_imm      = '0;
      d_rd       = '0;
      d_rw       = 1'b0;
      d_mr       = 1'b0;
      d_mw       = 1'b0;
      d_br       = 1'b0;
      d_inv      = 1'b0;
      d_ill      = 1'b0;
      d_zero_rs1 = 1'b0;
      case (opcode)
         OP_R: begin
            d_rw = 1'b1;
            d_rd = in_inst[11:7];
            if (funct7 == 7'b0000000) d_ctrl = f3_ctrl(funct3);
            else if (funct7 == 7'b0100000 && funct3 == 3'b000) d_ctrl = C_SUB;
            else if (funct7 == 7'b0100000 && funct3 == 3'b101) d_ctrl = C_SRA;
            else d_ill = 1'b1;
         end
         OP_I: begin
            d_src  = 1'b1;
            d_rw   = 1'b1;
            d_rd   = in_inst[11:7];
            d_imm  = imm_i;
            d_ctrl = f3_ctrl(funct3);
            if (funct3 == 3'b001 && funct7 != 7'b0000000) d_ill = 1'b1;
            if (funct3 == 3'b101) begin
               if (funct7 == 7'b0100000) d_ctrl = C_SRA;
               else if (funct7 != 7'b0000000) d_ill = 1'b1;
            end
         end
         OP_LOAD: begin
            d_src = 1'b1;
            d_rw  = 1'b1;
            d_mr  = 1'b1;
            d_rd  = in_inst[11:7];
            d_imm = imm_i;
            d_ill = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
         end
         OP_ST: begin
            d_src = 1'b1;
            d_mw  = 1'b1;
            d_imm = imm_s;
            d_ill = funct3[2] || (funct3 == 3'b011);
         end
         OP_BR: begin
            d_br  = 1'b1;
            d_imm = imm_b;
            d_inv = funct3[0];
            case (funct3[2:1])
               2'b00:   d_ctrl = C_XOR;
               2'b10:   d_ctrl = C_SLT;
               2'b11:   d_ctrl = C_SLTU;
               default: d_ill  = 1'b1;
            endcase
         end
         OP_LUI: begin
            d_src      = 1'b1;
            d_rw       = 1'b1;
            d_rd       = in_inst[11:7];
            d_imm      = imm_u;
            d_zero_rs1 = 1'b1;
         end
         default: d_ill = 1'b1;
      endcase
      // Illegal entries still flow, but must have no side effects downstream.
      if (d_ill) begin
         d_ctrl = C_ADD;
         d_src  = 1'b0;
         d_rw   = 1'b0;
         d_mr   = 1'b0;
         d_mw   = 1'b0;
         d_br   = 1'b0;
         d_inv  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid     <= 1'b0;
         out_alu_ctrl  <= C_ADD;
         out_alu_src   <= 1'b0;
         out_imm       <= '0;
         out_rdata1    <= '0;
         out_rdata2    <= '0;
         out_rd        <= '0;
         out_reg_write <= 1'b0;
         out_mem_read  <= 1'b0;
         out_mem_write <= 1'b0;
         out_branch    <= 1'b0;
         out_br_invert <= 1'b0;
         out_illegal   <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid     <= 1'b1;
         out_alu_ctrl  <= d_ctrl;
         out_alu_src   <= d_src;
         out_imm       <= ALU_BITS'($signed(d_imm));
         out_rdata1    <= d_zero_rs1 ? '0 : in_rdata1;
         out_rdata2    <= in_rdata2;
         out_rd        <= d_rd;
         out_reg_write <= d_rw;
         out_mem_read  <= d_mr;
         out_mem_write <= d_mw;
         out_branch    <= d_br;
         out_br_invert <= d_inv;
         out_illegal   <= d_ill;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed scenarios and random traffic checked against a
// cycle-level behavioural model of the issue register and an RV32I decode table.
module tb_alu_issue;

   logic        clk, rst;
   logic        in_valid, in_ready, flush, out_valid, out_ready;
   logic [31:0] in_inst, in_rdata1, in_rdata2;
   logic [3:0]  out_alu_ctrl;
   logic        out_alu_src;
   logic [31:0] out_imm, out_rdata1, out_rdata2;
   logic [4:0]  out_rd;
   logic        out_reg_write, out_mem_read, out_mem_write, out_branch, out_br_invert, out_illegal;

   alu_issue dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
      .in_rdata1(in_rdata1), .in_rdata2(in_rdata2), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_alu_ctrl(out_alu_ctrl), .out_alu_src(out_alu_src),
      .out_imm(out_imm), .out_rdata1(out_rdata1), .out_rdata2(out_rdata2), .out_rd(out_rd),
      .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
      .out_branch(out_branch), .out_br_invert(out_br_invert), .out_illegal(out_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  ctrl;
      logic        src;
      logic [31:0] imm;
      logic [31:0] r1;
      logic [31:0] r2;
      logic [4:0]  rd;
      logic        rw, mr, mw, br, inv, ill;
      logic        chk_imm, chk_rd;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [3:0] rmap [8];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
      end
   endtask

   // Reference decode: legality and fields straight from the RV32I tables.
   function automatic exp_t exp_of(input logic [31:0] inst, input logic [31:0] r1, input logic [31:0] r2);
      exp_t e;
      logic [2:0] f3;
      logic [6:0] f7;
      logic legal;
      f3 = inst[14:12];
      f7 = inst[31:25];
      e = '0;
      e.r1 = r1;
      e.r2 = r2;
      legal = 1'b1;
      case (inst[6:0])
         7'h33: begin
            legal = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
            e.ctrl = (f7 == 0) ? rmap[f3] : ((f3 == 0) ? 4'd1 : 4'd7);
            e.rw = 1; e.rd = inst[11:7]; e.chk_rd = 1;
         end
         7'h13: begin
            if (f3 == 1) legal = (f7 == 0);
            else if (f3 == 5) legal = (f7 == 0) || (f7 == 7'h20);
            e.ctrl = (f3 == 5 && f7 == 7'h20) ? 4'd7 : rmap[f3];
            e.src = 1; e.imm = 32'(signed'(inst[31:20])); e.chk_imm = 1;
            e.rw = 1; e.rd = inst[11:7]; e.chk_rd = 1;
         end
         7'h03: begin
            legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
            e.src = 1; e.imm = 32'(signed'(inst[31:20])); e.chk_imm = 1;
            e.mr = 1; e.rw = 1; e.rd = inst[11:7]; e.chk_rd = 1;
         end
         7'h23: begin
            legal = (f3 < 3);
            e.src = 1; e.imm = 32'(signed'({inst[31:25], inst[11:7]})); e.chk_imm = 1;
            e.mw = 1; e.rd = 0; e.chk_rd = 1;
         end
         7'h63: begin
            legal = (f3 != 2) && (f3 != 3);
            e.ctrl = (f3 < 2) ? 4'd5 : ((f3 < 6) ? 4'd3 : 4'd4);
            e.inv = f3[0]; e.br = 1; e.chk_imm = 1;
            e.imm = 32'(signed'({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
         end
         7'h37: begin
            e.src = 1; e.imm = inst & 32'hFFFFF000; e.chk_imm = 1;
            e.r1 = 0; e.rw = 1; e.rd = inst[11:7]; e.chk_rd = 1;
         end
         default: legal = 1'b0;
      endcase
      if (!legal) begin
         e.ctrl = 0; e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0; e.ill = 1;
      end
      return e;
   endfunction

   task automatic check_outputs();
      exp_t e;
      check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         e = exp_q[0];
         check("alu_ctrl", 64'(out_alu_ctrl), 64'(e.ctrl));
         check("reg_write", 64'(out_reg_write), 64'(e.rw));
         check("mem_read", 64'(out_mem_read), 64'(e.mr));
         check("mem_write", 64'(out_mem_write), 64'(e.mw));
         check("branch", 64'(out_branch), 64'(e.br));
         check("illegal", 64'(out_illegal), 64'(e.ill));
         if (!e.ill) begin
            check("alu_src", 64'(out_alu_src), 64'(e.src));
            check("br_invert", 64'(out_br_invert), 64'(e.inv));
            check("rdata1", 64'(out_rdata1), 64'(e.r1));
            check("rdata2", 64'(out_rdata2), 64'(e.r2));
            if (e.chk_imm) check("imm", 64'(out_imm), 64'(e.imm));
            if (e.chk_rd) check("rd", 64'(out_rd), 64'(e.rd));
         end
      end
   endtask

   // One clock cycle: drive at negedge, check in_ready, advance model at posedge, check outputs.
   task automatic cycle(input logic iv, input logic [31:0] inst, input logic [31:0] r1,
                        input logic [31:0] r2, input logic ordy, input logic fl);
      logic held, acc;
      @(negedge clk);
      in_valid = iv; in_inst = inst; in_rdata1 = r1; in_rdata2 = r2;
      out_ready = ordy; flush = fl;
      #1;
      held = (exp_q.size() != 0);
      check("in_ready", 64'(in_ready), 64'(!held || ordy));
      acc = iv && (!held || ordy);
      @(posedge clk);
      if (fl) exp_q.delete();
      else if (acc) begin
         exp_q.delete();
         exp_q.push_back(exp_of(inst, r1, r2));
      end else if (ordy) exp_q.delete();
      #1;
      check_outputs();
   endtask

   function automatic logic [31:0] rand_inst();
      logic [31:0] w;
      logic [6:0]  ops [8];
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h33, 7'h13};
      w = $urandom;
      if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 7)];
      case ($urandom_range(0, 3))
         0: w[31:25] = 7'h00;
         1: w[31:25] = 7'h20;
         default: ;
      endcase
      return w;
   endfunction

   initial begin
      rmap = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
      rst = 1'b1; in_valid = 0; in_inst = 0; in_rdata1 = 0; in_rdata2 = 0;
      out_ready = 0; flush = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_valid", 64'(out_valid), 64'(0));
      check("reset_ctrl", 64'(out_alu_ctrl), 64'(0));
      check("reset_in_ready", 64'(in_ready), 64'(1));

      // Reset mid-stall drops the entry without a clock edge.
      cycle(1, 32'h002081B3, 32'h11, 32'h22, 0, 0);
      @(negedge clk);
      in_valid = 0;
      #2 rst = 1'b1;
      #1;
      check("rst_async_valid", 64'(out_valid), 64'(0));
      check("rst_async_rw", 64'(out_reg_write), 64'(0));
      check("rst_async_rd", 64'(out_rd), 64'(0));
      check("rst_async_rdata1", 64'(out_rdata1), 64'(0));
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      #1 check("rst_release_in_ready", 64'(in_ready), 64'(1));

      // ADD then SUB back-to-back.
      cycle(1, 32'h002081B3, 32'd5, 32'd7, 1, 0);
      check("add_ctrl", 64'(out_alu_ctrl), 64'(0));
      cycle(1, 32'h402081B3, 32'd5, 32'd7, 1, 0);
      check("sub_ctrl", 64'(out_alu_ctrl), 64'(1));
      check("sub_rd", 64'(out_rd), 64'(3));
      cycle(0, 0, 0, 0, 1, 0);

      // ADDI held through a 3-cycle stall.
      cycle(1, 32'hFFF00293, 32'h1234, 32'h5678, 0, 0);
      check("addi_imm", 64'(out_imm), 64'hFFFFFFFF);
      check("addi_rd", 64'(out_rd), 64'(5));
      repeat (3) cycle(1, 32'h002081B3, 32'h1, 32'h2, 0, 0);
      cycle(0, 0, 0, 0, 1, 0);

      // SRAI and its malformed variant.
      cycle(1, 32'h4032D313, 32'hAA, 32'hBB, 1, 0);
      check("srai_ctrl", 64'(out_alu_ctrl), 64'(7));
      check("srai_shamt", 64'(out_imm[4:0]), 64'(3));
      check("srai_rd", 64'(out_rd), 64'(6));
      cycle(1, 32'h6032D313, 32'hAA, 32'hBB, 1, 0);
      check("srai_bad_ill", 64'(out_illegal), 64'(1));
      check("srai_bad_rw", 64'(out_reg_write), 64'(0));

      // BNE x1,x2,-4.
      cycle(1, 32'hFE209EE3, 32'h3, 32'h4, 1, 0);
      check("bne_ctrl", 64'(out_alu_ctrl), 64'(5));
      check("bne_inv", 64'(out_br_invert), 64'(1));
      check("bne_imm", 64'(out_imm), 64'hFFFFFFFC);

      // Flush during consume+accept, then an undefined opcode.
      cycle(1, 32'h002081B3, 32'h9, 32'h8, 0, 0);
      cycle(1, 32'h402081B3, 32'h9, 32'h8, 1, 1);
      check("flush_valid", 64'(out_valid), 64'(0));
      cycle(0, 0, 0, 0, 1, 0);
      cycle(1, 32'h0000007F, 32'h1, 32'h2, 1, 0);
      check("undef_ill", 64'(out_illegal), 64'(1));
      check("undef_quals", 64'({out_reg_write, out_mem_read, out_mem_write, out_branch}), 64'(0));

      // Random traffic with random backpressure and occasional flush.
      for (int i = 0; i < 2000; i++) begin
         cycle(($urandom_range(0, 3) != 0), rand_inst(), $urandom, $urandom,
               ($urandom_range(0, 2) != 0), ($urandom_range(0, 11) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- ID/EX issue stage that produces everything the ALU consumes:
  - ALU control code and operand-select bit.
  - Sign-extended immediate and the two register operands.
  - Branch/memory/writeback qualifiers.
- Decodes one RV32I instruction word plus its register-file read data.
- Holds the result in a single-entry pipeline register with a valid/ready handshake, stall and flush.
- Sits between the register-file read and the ALU.

Parameters:
- ALU_BITS, 32, datapath width of operands and immediate.
- ALU_CTRL_BITS, 4, width of the ALU control code.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  instruction and operands are presented this cycle.
- in_ready  output  1  stage accepts input this cycle.
- in_inst  input  32  instruction word.
- in_rdata1  input  ALU_BITS  rs1 read data.
- in_rdata2  input  ALU_BITS  rs2 read data.
- flush  input  1  kill the held entry and any entry being accepted.
- out_valid  output  1  registered outputs are valid.
- out_ready  input  1  ALU/EX consumes the entry this cycle.
- out_alu_ctrl  output  ALU_CTRL_BITS  ALU operation code.
- out_alu_src  output  1  0 = rdata2 operand, 1 = imm operand.
- out_imm  output  ALU_BITS  sign-extended immediate.
- out_rdata1  output  ALU_BITS  operand 1 (forced 0 for LUI).
- out_rdata2  output  ALU_BITS  operand 2 (store data for stores).
- out_rd  output  5  destination register.
- out_reg_write  output  1  write rd at writeback.
- out_mem_read  output  1  load.
- out_mem_write  output  1  store.
- out_branch  output  1  conditional branch.
- out_br_invert  output  1  taken when ALU condition is false (BNE/BGE/BGEU).
- out_illegal  output  1  unsupported or malformed encoding.

Behaviour:
- Reset: rst=1 immediately clears all registered outputs to 0, including out_valid; out_alu_ctrl=ADD (0). The entry is dropped even mid-handshake.
- ALU control encoding: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9; 10-15 unused.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready.
  - Latency is one cycle: decoded fields appear on the cycle after acceptance.
  - While out_valid=1 and out_ready=0, all outputs hold stable.
  - If out_ready=1 and no accept, out_valid clears next cycle.
  - Simultaneous consume and accept replaces the entry back-to-back with no bubble.
- Flush:
  - flush=1 clears out_valid next cycle and discards any same-cycle acceptance.
  - in_ready is unaffected by flush.
  - Flush has priority over accept and hold.
- Decode by opcode (inst[6:0]):
  - 0110011 R-type: alu_src=0, reg_write=1.
    - funct7 must be 0000000, or 0100000 only with funct3 000 (SUB) or 101 (SRA); otherwise illegal.
    - funct3 map: 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
  - 0010011 I-arith: same map without SUB, alu_src=1, reg_write=1, I-immediate.
    - For funct3 001, inst[31:25] must be 0.
    - For funct3 101, inst[31:25] must be 0000000 (SRLI) or 0100000 (SRAI); otherwise illegal.
  - 0000011 load: funct3 000/001/010/100/101 only, else illegal. ADD, alu_src=1, I-immediate, mem_read=1, reg_write=1.
  - 0100011 store: funct3 000/001/010 only, else illegal. ADD, alu_src=1, S-immediate, mem_write=1, rd=0.
  - 1100011 branch: B-immediate (bit 0 = 0), alu_src=0, branch=1.
    - funct3 map: 000 XOR/inv0, 001 XOR/inv1, 100 SLT/inv0, 101 SLT/inv1, 110 SLTU/inv0, 111 SLTU/inv1.
    - funct3 010/011 are illegal.
  - 0110111 LUI: ADD, alu_src=1, U-immediate (inst[31:12]<<12), out_rdata1=0, reg_write=1.
- Illegal entries:
  - Any other opcode is illegal.
  - An illegal entry still flows with out_valid=1 and out_illegal=1.
  - reg_write, mem_read, mem_write and branch are all 0; alu_ctrl=ADD.
- rd: when rd=0, reg_write is still set as decoded; writeback ignores x0.
- Immediates: all immediates are sign-extended from inst[31] to ALU_BITS.

Test Plan:
- Reset mid-stall:
  - Stimulus: accept 0x002081B3 with out_ready=0, then assert rst.
  - Response: out_valid drops to 0 without waiting for a clock edge, outputs return to 0, and in_ready=1 after release.
- ADD then SUB back-to-back with out_ready=1:
  - Stimulus: 0x002081B3 then 0x402081B3.
  - Response: alu_ctrl 0 then 1 on consecutive cycles, alu_src=0, rd=3, reg_write=1, in_ready held 1.
- ADDI with stall:
  - Stimulus: ADDI 0xFFF00293, with out_ready=0 for 3 cycles.
  - Response: imm=0xFFFFFFFF, alu_src=1, rd=5; outputs stable for 3 cycles; in_ready=0 until out_ready=1.
- SRAI:
  - Stimulus: SRAI 0x4032D313.
  - Response: alu_ctrl=7, imm low 5 bits = 3, rd=6.
  - Setting inst[29] (0x6032D313) gives illegal=1 with reg_write=0.
- BNE x1,x2,-4:
  - Stimulus: 0xFE209EE3.
  - Response: alu_ctrl=5, br_invert=1, branch=1, imm=0xFFFFFFFC, reg_write=0.
- Flush during simultaneous consume and accept:
  - Stimulus: flush asserted while out_valid=1, out_ready=1, in_valid=1.
  - Response: out_valid=0 next cycle and the accepted instruction is dropped.
  - Follow-up: opcode 0x7F gives out_illegal=1 with all qualifiers 0.
